// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: sequencing controller for a 4-bit serial pattern detector.
// It accepts a scan command (pattern, overlap mode, frame length) and pulls
// that many bits through a valid/ready handshake. For each bit it flags a
// match, counts the matches (saturating) and pulses done when the frame ends.
// Optional feature: define MATCH_LIMIT_EN to add a match_limit input. A
// nonzero limit ends the scan early, on the match that reaches the limit.
module pattern_scan_ctrl #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       pattern,
  input  logic             mode,
  input  logic [LEN_W-1:0] frame_len,
`ifdef MATCH_LIMIT_EN
  input  logic [CNT_W-1:0] match_limit,
`endif
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             busy,
  output logic             match_pulse,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [3:0]       pat_q;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [3:0]       history;
  logic [LEN_W-1:0] bit_cnt;
  logic [2:0]       since_cnt;

  logic             accept;
  logic [3:0]       window_next;
  logic [2:0]       since_inc;
  logic             is_match;
  logic [CNT_W-1:0] count_inc;
  logic [LEN_W-1:0] bit_cnt_inc;
  logic             last_bit;
  logic             limit_hit;

`ifdef MATCH_LIMIT_EN
  logic [CNT_W-1:0] limit_q;
`endif

  assign bit_ready = (state == SCAN) && !abort;
  assign busy      = (state != IDLE);

  // Next-value terms for the bit that may be accepted this cycle
  always_comb begin
    accept      = (state == SCAN) && bit_valid && !abort;
    window_next = {history[2:0], bit_in};
    since_inc   = (since_cnt >= 3'd4) ? 3'd4 : since_cnt + 3'd1;
    is_match    = accept && (window_next == pat_q) && (since_inc >= 3'd4);
    count_inc   = (match_count == {CNT_W{1'b1}}) ? match_count : match_count + CNT_W'(1);
    bit_cnt_inc = bit_cnt + LEN_W'(1);
    last_bit    = (bit_cnt_inc == len_q);
`ifdef MATCH_LIMIT_EN
    limit_hit   = is_match && (limit_q != '0) && (count_inc == limit_q);
`else
    limit_hit   = 1'b0;
`endif
  end

  // Controller FSM with its counters, history window and registered pulses
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pat_q       <= '0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      history     <= '0;
      bit_cnt     <= '0;
      since_cnt   <= '0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
`ifdef MATCH_LIMIT_EN
      limit_q     <= '0;
`endif
    end else begin
      match_pulse <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q       <= pattern;
            mode_q      <= mode;
            len_q       <= frame_len;
`ifdef MATCH_LIMIT_EN
            limit_q     <= match_limit;
`endif
            match_count <= '0;
            bit_cnt     <= '0;
            since_cnt   <= '0;
            if (frame_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            history <= window_next;
            bit_cnt <= bit_cnt_inc;
            if (is_match) begin
              match_pulse <= 1'b1;
              match_count <= count_inc;
              since_cnt   <= mode_q ? since_inc : 3'd0;
            end else begin
              since_cnt   <= since_inc;
            end
            if (last_bit || limit_hit) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl.
// The bench builds the DUT with LEN_W=10 so that a single frame can hold more
// than 255 matches, which exercises saturation of match_count.
module tb_pattern_scan_ctrl;

  localparam int LEN_W = 10;
  localparam int CNT_W = 8;

  logic             clock;
  logic             rst_n;
  logic             start;
  logic [3:0]       pattern;
  logic             mode;
  logic [LEN_W-1:0] frame_len;
  logic             abort;
  logic             bit_valid;
  logic             bit_in;
  logic             bit_ready;
  logic             busy;
  logic             match_pulse;
  logic             done;
  logic [CNT_W-1:0] match_count;
`ifdef MATCH_LIMIT_EN
  logic [CNT_W-1:0] match_limit;
`endif

  int checks = 0;
  int errors = 0;

  pattern_scan_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .pattern     (pattern),
    .mode        (mode),
    .frame_len   (frame_len),
`ifdef MATCH_LIMIT_EN
    .match_limit (match_limit),
`endif
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .bit_ready   (bit_ready),
    .busy        (busy),
    .match_pulse (match_pulse),
    .done        (done),
    .match_count (match_count)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present one bit for one clock, then check the registered pulses
  task automatic applyStimulus(input logic valid, input logic b, input logic exp_m,
                               input logic exp_d, input string tag);
    bit_valid = valid;
    bit_in    = b;
    @(posedge clock);
    #1;
    bit_valid = 1'b0;
    checkOutput({tag, "_match"}, match_pulse, exp_m);
    checkOutput({tag, "_done"}, done, exp_d);
  endtask

  task automatic start_scan(input logic [3:0] p, input logic m, input logic [LEN_W-1:0] len);
    pattern   = p;
    mode      = m;
    frame_len = len;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  initial begin
    logic [7:0]  bits8;
    logic [7:0]  exp8;
    logic [12:0] valid_seq;
    int          acc;

    rst_n = 1'b0; start = 1'b0; pattern = 4'h0; mode = 1'b0; frame_len = '0;
    abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
`ifdef MATCH_LIMIT_EN
    match_limit = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_ready", bit_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_match", match_pulse, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_count", match_count, 0);
    rst_n = 1'b1;
    @(posedge clock);
    #1;

    // Overlapping 1010 stream: matches after bits 4, 6 and 8
    bits8 = 8'b10101010;
    exp8  = 8'b00010101;
    start_scan(4'b1010, 1'b1, 8);
    pattern = 4'b0000;
    mode    = 1'b0;
    checkOutput("ov_busy", busy, 1'b1);
    checkOutput("ov_ready", bit_ready, 1'b1);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, bits8[7-i], exp8[7-i], (i == 7), $sformatf("ov_bit%0d", i));
    checkOutput("ov_count", match_count, 3);
    checkOutput("ov_busy_done", busy, 1'b1);
    @(posedge clock);
    #1;
    checkOutput("ov_idle_busy", busy, 1'b0);
    checkOutput("ov_idle_done", done, 1'b0);
    checkOutput("ov_hold_count", match_count, 3);

    // Nonoverlapping: matches after bits 4 and 8 only
    exp8 = 8'b00010001;
    start_scan(4'b1010, 1'b0, 8);
    checkOutput("nov_clear", match_count, 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, bits8[7-i], exp8[7-i], (i == 7), $sformatf("nov_bit%0d", i));
    checkOutput("nov_count", match_count, 2);
    @(posedge clock);
    #1;

    // Back-pressure, both modes: bits only count when valid
    valid_seq = 13'b1001001001001;
    for (int m = 0; m < 2; m++) begin
      start_scan(4'b1111, m[0], 5);
      acc = 0;
      for (int i = 0; i < 13; i++) begin
        if (valid_seq[12-i]) acc++;
        applyStimulus(valid_seq[12-i], 1'b1,
                      valid_seq[12-i] && (m == 1 ? acc >= 4 : acc == 4),
                      valid_seq[12-i] && acc == 5,
                      $sformatf("bp%0d_c%0d", m, i));
      end
      checkOutput($sformatf("bp%0d_count", m), match_count, m == 1 ? 2 : 1);
      @(posedge clock);
      #1;
      checkOutput($sformatf("bp%0d_idle", m), busy, 1'b0);
    end

    // Abort after 6 accepts; a start during the scan is ignored
    start_scan(4'b1010, 1'b0, 10);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "ab_b0");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "ab_b1");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "ab_b2");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "ab_b3");
    start = 1'b1; frame_len = '0; pattern = 4'b0000;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "ab_b4");
    start = 1'b0;
    checkOutput("ab_still_busy", busy, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "ab_b5");
    abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    #1;
    checkOutput("ab_ready_low", bit_ready, 1'b0);
    @(posedge clock);
    #1;
    abort = 1'b0; bit_valid = 1'b0;
    checkOutput("ab_busy", busy, 1'b0);
    checkOutput("ab_done", done, 1'b0);
    checkOutput("ab_count", match_count, 1);
    @(posedge clock);
    #1;
    checkOutput("ab_no_done", done, 1'b0);

    // Zero-length frame goes straight to DONE, accepting nothing
    bit_valid = 1'b1; bit_in = 1'b1;
    start_scan(4'b1111, 1'b1, 0);
    checkOutput("z_busy", busy, 1'b1);
    checkOutput("z_done", done, 1'b1);
    checkOutput("z_ready", bit_ready, 1'b0);
    checkOutput("z_count", match_count, 0);
    @(posedge clock);
    #1;
    bit_valid = 1'b0;
    checkOutput("z_idle", busy, 1'b0);
    checkOutput("z_done_low", done, 1'b0);

    // 303 ones, overlapping 1111: 300 matches, count saturates at 255
    start_scan(4'b1111, 1'b1, 303);
    bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 303; i++) begin
      @(posedge clock);
      #1;
      if (i == 257) checkOutput("sat_reach", match_count, 255);
    end
    bit_valid = 1'b0;
    checkOutput("sat_done", done, 1'b1);
    checkOutput("sat_pulse", match_pulse, 1'b1);
    checkOutput("sat_count", match_count, 255);
    @(posedge clock);
    #1;

`ifdef MATCH_LIMIT_EN
    // Limit of 2 ends the scan on the second match
    bits8 = 8'b10101010;
    exp8  = 8'b00010100;
    match_limit = 2;
    start_scan(4'b1010, 1'b1, 20);
    match_limit = 0;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, bits8[7-i], exp8[7-i], (i == 5), $sformatf("lim_bit%0d", i));
    checkOutput("lim_count", match_count, 2);
    checkOutput("lim_ready", bit_ready, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("lim_idle", busy, 1'b0);
    checkOutput("lim_ready_idle", bit_ready, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
